// File: rtl/cpu_pkg.sv
// Shared CPU types: bus phase encoding and
// the memory responder's FSM states.
package cpu_pkg;

  typedef enum logic [1:0] {
    PH_FETCH   = 2'd0,
    PH_DECODE  = 2'd1,
    PH_EXECUTE = 2'd2,
    PH_STORE   = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RESP    = 2'd2,
    ST_RELEASE = 2'd3
  } rsp_state_e;

endpackage

// File: rtl/mem_array.sv
// DEPTH x DW register array: synchronous write,
// combinational read, asynchronous clear.
module mem_array #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int IW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_we,
  input  logic [IW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [IW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  // storage: clear on reset, write on enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: four-phase req/ack with a
// programmable wait, range and protocol error flag.
module mem_responder
  import cpu_pkg::*;
#(
  parameter int DW          = 8,
  parameter int AW          = 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    phase,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ack,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW =
    (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  rsp_state_e    r_state;
  rsp_state_e    w_next;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_addr;
  logic          r_we;
  logic [DW-1:0] r_wdata;
  logic          r_ack;
  logic [DW-1:0] r_rdata;
  logic          r_err;

  logic          w_start;
  logic          w_commit;
  logic [AW-1:0] w_addr;
  logic          w_we;
  logic [DW-1:0] w_wdata;
  logic          w_inrange;
  logic          w_mem_we;
  logic [DW-1:0] w_mem_rd;
  logic          w_bad_phase;
  logic          w_err_set;

  // with no wait the access commits straight from
  // IDLE, before the latch is loaded, so use inputs
  assign w_start  = (r_state == ST_IDLE) && req;
  assign w_commit = (WAIT_CYCLES == 0) ? w_start
                  : (r_state == ST_BUSY) &&
                    (r_cnt == '0);
  assign w_addr   = (WAIT_CYCLES == 0) ? addr  : r_addr;
  assign w_we     = (WAIT_CYCLES == 0) ? we    : r_we;
  assign w_wdata  = (WAIT_CYCLES == 0) ? wdata : r_wdata;

  assign w_inrange = {1'b0, w_addr} < DEPTH_L;
  assign w_mem_we  = w_commit && w_we && w_inrange;

  assign w_bad_phase = (phase == PH_DECODE) ||
                       (phase == PH_EXECUTE);
  assign w_err_set =
    (w_start && w_bad_phase) ||
    ((r_state == ST_BUSY) && !req) ||
    (w_commit && !w_inrange);

  mem_array #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_mem_we),
    .i_waddr (w_addr[IW-1:0]),
    .i_wdata (w_wdata),
    .i_raddr (w_addr[IW-1:0]),
    .o_rdata (w_mem_rd)
  );

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:
        if (req)
          w_next = (WAIT_CYCLES == 0) ? ST_RESP
                                      : ST_BUSY;
      ST_BUSY:
        if (r_cnt == '0) w_next = ST_RESP;
      ST_RESP:
        w_next = ST_RELEASE;
      ST_RELEASE:
        if (!req) w_next = ST_IDLE;
      default:
        w_next = ST_IDLE;
    endcase
  end

  // request latch, wait counter, response and error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_ack   <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_start) begin
        r_addr  <= addr;
        r_we    <= we;
        r_wdata <= wdata;
        r_cnt   <= CNT_LOAD;
      end else if ((r_state == ST_BUSY) &&
                   (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_commit && !w_we)
        r_rdata <= w_inrange ? w_mem_rd : '0;
      r_ack <= (r_state == ST_RESP);
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign ack   = r_ack;
  assign rdata = r_rdata;
  assign busy  = (r_state != ST_IDLE);
  assign err   = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT_CYCLES=2
// and a WAIT_CYCLES=0 instance on shared inputs.
module tb_mem_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] phase;
  logic       req;
  logic       we;
  logic [7:0] addr;
  logic [7:0] wdata;

  logic       ack2, busy2, err2;
  logic [7:0] rdata2;
  logic       ack0, busy0, err0;
  logic [7:0] rdata0;

  logic       sel;
  logic       s_ack, s_busy, s_err;
  logic [7:0] s_rdata;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_responder #(
    .DW(8), .AW(8), .DEPTH(16), .WAIT_CYCLES(2)
  ) u_dut2 (
    .clk(clk), .reset(reset), .phase(phase),
    .req(req), .we(we), .addr(addr),
    .wdata(wdata), .ack(ack2), .rdata(rdata2),
    .busy(busy2), .err(err2)
  );

  mem_responder #(
    .DW(8), .AW(8), .DEPTH(16), .WAIT_CYCLES(0)
  ) u_dut0 (
    .clk(clk), .reset(reset), .phase(phase),
    .req(req), .we(we), .addr(addr),
    .wdata(wdata), .ack(ack0), .rdata(rdata0),
    .busy(busy0), .err(err0)
  );

  always_comb begin
    s_ack   = sel ? ack0   : ack2;
    s_busy  = sel ? busy0  : busy2;
    s_err   = sel ? err0   : err2;
    s_rdata = sel ? rdata0 : rdata2;
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic access(
    input string      tag,
    input logic [1:0] ph,
    input logic       w,
    input logic [7:0] a,
    input logic [7:0] d,
    input int         exp_lat,
    input logic [7:0] exp_rd,
    input bit         drop
  );
    int lat;
    lat = -1;
    @(negedge clk);
    phase = ph; we = w; addr = a; wdata = d;
    req = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 16 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 0 && drop) req = 1'b0;
      if (s_ack) lat = k;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_rdata"}, s_rdata, exp_rd);
    check({tag, "_busy_ack"}, s_busy, 1);
    req = 1'b0;
    @(negedge clk);
    check({tag, "_ack_1cyc"}, s_ack, 0);
    check({tag, "_busy_rel"}, s_busy, 0);
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    req   = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int acks;
    reset = 1'b1;
    sel   = 1'b0;
    phase = 2'd0; req = 1'b0; we = 1'b0;
    addr  = 8'd0; wdata = 8'd0;
    #12;
    check("rst_ack",   s_ack,   0);
    check("rst_rdata", s_rdata, 0);
    check("rst_busy",  s_busy,  0);
    check("rst_err",   s_err,   0);
    @(negedge clk);
    reset = 1'b0;

    // 1: basic read
    access("t1_rd3", 2'd0, 1'b0, 8'd3, 8'h00,
           3, 8'h00, 1'b0);
    check("t1_err", s_err, 0);

    // 2: write then read back
    access("t2_wr5", 2'd3, 1'b1, 8'd5, 8'hA5,
           3, 8'h00, 1'b0);
    access("t2_rd5", 2'd0, 1'b0, 8'd5, 8'h00,
           3, 8'hA5, 1'b0);
    check("t2_err", s_err, 0);

    // 3: out of range, no aliasing onto addr 4
    access("t3_rd20", 2'd0, 1'b0, 8'd20, 8'h00,
           3, 8'h00, 1'b0);
    check("t3_err_rd", s_err, 1);
    access("t3_wr20", 2'd3, 1'b1, 8'd20, 8'h11,
           3, 8'h00, 1'b0);
    access("t3_rd4", 2'd0, 1'b0, 8'd4, 8'h00,
           3, 8'h00, 1'b0);
    check("t3_err_sticky", s_err, 1);
    do_reset();
    check("t3_err_clr", s_err, 0);

    // 4: bad phase still serviced; held req
    access("t4_wr6", 2'd3, 1'b1, 8'd6, 8'h77,
           3, 8'h00, 1'b0);
    check("t4_err_ok", s_err, 0);
    access("t4_rd6_ex", 2'd2, 1'b0, 8'd6, 8'h00,
           3, 8'h77, 1'b0);
    check("t4_err_phase", s_err, 1);
    @(negedge clk);
    phase = 2'd0; we = 1'b0; addr = 8'd6;
    req = 1'b1;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (s_ack) acks++;
    end
    check("t4_first_ack", acks, 1);
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (s_ack) acks++;
    end
    check("t4_hold_noack", acks, 0);
    check("t4_hold_busy", s_busy, 1);
    req = 1'b0;
    access("t4_rerise", 2'd0, 1'b0, 8'd6, 8'h00,
           3, 8'h77, 1'b0);

    // 5: reset in BUSY of a write
    @(negedge clk);
    phase = 2'd3; we = 1'b1; addr = 8'd7;
    wdata = 8'h3C; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t5_busy_pre", s_busy, 1);
    #1 reset = 1'b1;
    #1;
    check("t5_async_ack",   s_ack,   0);
    check("t5_async_rdata", s_rdata, 0);
    check("t5_async_busy",  s_busy,  0);
    check("t5_async_err",   s_err,   0);
    req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (s_ack) acks++;
    end
    check("t5_no_ack", acks, 0);
    access("t5_rd7", 2'd0, 1'b0, 8'd7, 8'h00,
           3, 8'h00, 1'b0);
    check("t5_err", s_err, 0);

    // req dropped while BUSY
    access("t5_drop", 2'd0, 1'b0, 8'd5, 8'h00,
           3, 8'h00, 1'b1);
    check("t5_drop_err", s_err, 1);

    // 6: zero-wait instance
    do_reset();
    sel = 1'b1;
    check("t6_rst_err", s_err, 0);
    access("t6_rd3", 2'd0, 1'b0, 8'd3, 8'h00,
           1, 8'h00, 1'b0);
    access("t6_wr2", 2'd3, 1'b1, 8'd2, 8'h42,
           1, 8'h00, 1'b0);
    access("t6_rd2", 2'd0, 1'b0, 8'd2, 8'h00,
           1, 8'h42, 1'b0);
    access("t6_rd15", 2'd0, 1'b0, 8'd15, 8'h00,
           1, 8'h00, 1'b0);
    check("t6_err", s_err, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule
